serial_feed_ctrl: RTL and testbench
===================================

SERIAL_FEED_CTRL -- requirements
Module: serial_feed_ctrl

Interface
REQ-001 SHALL have parameter IN_WIDTH, default `DATA_WIDTH*`IF_WIDTH, giving the width of one serial word.
REQ-002 SHALL have parameter NUM, default `KERNEL_WIDTH, giving the number of words per row (≥2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, giving the buffer address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH: address of word 0 of row 0, latched on start.
REQ-008 SHALL have port row_stride, input, ADDR_WIDTH: address step between rows, latched on start.
REQ-009 SHALL have port num_rows, input, 8: number of rows, latched on start.
REQ-010 SHALL have port row_ready, input, 1: downstream may accept a new parallel row.
REQ-011 SHALL have port mem_rd_en, output, 1: buffer read strobe.
REQ-012 SHALL have port mem_rd_addr, output, ADDR_WIDTH: buffer read address.
REQ-013 SHALL have port mem_rd_data, input, IN_WIDTH: buffer data, valid exactly 1 cycle after mem_rd_en.
REQ-014 SHALL have port out_serial, output, IN_WIDTH: serial word to the serial-to-parallel stage, combinationally equal to mem_rd_data.
REQ-015 SHALL have port begin_serial_in, output, 1: high in the cycle word 0 of a row is on out_serial.
REQ-016 SHALL have port refresh_parallel_array, output, 1: one-cycle pulse that commits the assembled row downstream.
REQ-017 SHALL have port busy, output, 1: a transfer is in progress.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-019 SHALL have port row_cnt, output, 8: number of rows committed so far.
REQ-020 SHALL have port stall_cycles, output, 16: row_ready back-pressure count (see Configuration).

Function
REQ-021 FSM states SHALL be IDLE, READ, DRAIN, WAIT_REFRESH and FINISH.
REQ-022 IDLE: start=1 in cycle c SHALL latch the parameters and enter READ at c+1; start=0 SHALL keep IDLE.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 READ SHALL assert mem_rd_en for exactly NUM consecutive cycles with no gaps; word k of row r SHALL use address base_addr + r*row_stride + k, truncated modulo 2^ADDR_WIDTH, so addresses wrap.
REQ-025 begin_serial_in SHALL be a registered copy of "mem_rd_en for word 0", so it is high 1 cycle after the word-0 read, aligned with its data.
REQ-026 After the NUM-th read the FSM SHALL spend 1 cycle in DRAIN, during which the last word is on out_serial, and then enter WAIT_REFRESH.
REQ-027 WAIT_REFRESH SHALL assert refresh_parallel_array for 1 cycle in the first cycle with row_ready=1, and SHALL increment row_cnt in that same edge.
REQ-028 With row_ready=1, refresh SHALL occur NUM+1 cycles after the row's first read.
REQ-029 After refresh, if row_cnt+1 < num_rows the FSM SHALL return to READ for the next row; otherwise it SHALL enter FINISH.
REQ-030 The next row's first read SHALL follow refresh by exactly 1 cycle, and no read SHALL overlap a pending refresh.
REQ-031 FINISH SHALL pulse done for 1 cycle and return to IDLE; busy SHALL be low in the FINISH cycle.
REQ-032 num_rows=0 SHALL produce no reads, SHALL go IDLE→FINISH, and SHALL pulse done 2 cycles after start.
REQ-033 busy SHALL be high in READ, DRAIN and WAIT_REFRESH, and low otherwise.
REQ-034 row_cnt SHALL clear on accepted start and hold its final value after done.

Reset
REQ-035 reset SHALL return the FSM to IDLE and drive mem_rd_en, begin_serial_in, refresh_parallel_array, busy and done to 0.
REQ-036 reset SHALL drive mem_rd_addr, row_cnt and stall_cycles to 0.
REQ-037 reset mid-transfer SHALL drop in-flight data with no refresh or done, and reset SHALL take priority over start in the same cycle.

Configuration
REQ-038 Macro SERIAL_FEED_STALL_CNT_EN SHALL select the back-pressure counter.
REQ-039 With SERIAL_FEED_STALL_CNT_EN defined, stall_cycles SHALL count cycles in WAIT_REFRESH with row_ready=0, clear on accepted start, and saturate at 16'hFFFF.
REQ-040 Without SERIAL_FEED_STALL_CNT_EN, stall_cycles SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-041 NUM=3, base 0x010, stride 4, num_rows=2, row_ready=1, start in cycle c -> reads 0x010–0x012 at c+1..c+3; begin at c+2; refresh at c+5; reads 0x014–0x016 at c+6..c+8; refresh c+10; done c+11; row_cnt=2.
REQ-042 As REQ-041 with row_ready=0 for 4 cycles from c+5 -> first refresh at c+9; stall_cycles=4 with the macro, 0 without.
REQ-043 base 0x3FE, ADDR_WIDTH=10, NUM=3, 1 row -> addresses 0x3FE, 0x3FF, 0x000.
REQ-044 num_rows=0 -> no mem_rd_en, done at c+2, busy never high.
REQ-045 reset at c+3 of REQ-041 -> all outputs 0 next cycle, no refresh or done; a new start then runs normally.
REQ-046 start pulsed while busy -> ignored, sequence identical to REQ-041.

Source files
------------

// File: rtl/serial_feed_ctrl.sv
// Serial feed controller: streams NUM buffer words per row into a serial-to-parallel stage.
// Optional back-pressure counter enabled by macro SERIAL_FEED_STALL_CNT_EN.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef IF_WIDTH
`define IF_WIDTH 4
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 3
`endif

module serial_feed_ctrl #(
  parameter int unsigned IN_WIDTH   = `DATA_WIDTH*`IF_WIDTH,
  parameter int unsigned NUM        = `KERNEL_WIDTH,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  input  logic [7:0]            num_rows,
  input  logic                  row_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [IN_WIDTH-1:0]   mem_rd_data,
  output logic [IN_WIDTH-1:0]   out_serial,
  output logic                  begin_serial_in,
  output logic                  refresh_parallel_array,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            row_cnt,
  output logic [15:0]           stall_cycles
);

  localparam int unsigned CNT_W = $clog2(NUM);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT_REFRESH,
    FINISH
  } state_t;

  state_t                r_state;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [7:0]            r_num_rows;
  logic [7:0]            r_row_cnt;
  logic [CNT_W-1:0]      r_word;
  logic                  r_begin;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_refresh;
  logic                  w_more_rows;
  logic [ADDR_WIDTH-1:0] w_next_base;

  // Refresh must land in the very cycle row_ready is seen, so it is decoded from state.
  assign w_refresh   = (r_state == WAIT_REFRESH) && row_ready;
  assign w_more_rows = ({1'b0, r_row_cnt} + 9'd1) < {1'b0, r_num_rows};
  assign w_next_base = r_row_base + r_stride;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_row_base    <= '0;
      r_stride      <= '0;
      r_num_rows    <= '0;
      r_row_cnt     <= '0;
      r_word        <= '0;
      r_begin       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_begin <= r_mem_rd_en && (r_word == '0);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_row_base <= base_addr;
            r_stride   <= row_stride;
            r_num_rows <= num_rows;
            r_row_cnt  <= '0;
            r_word     <= '0;
            if (num_rows == 8'd0) begin
              r_state <= FINISH;
            end else begin
              r_state       <= READ;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= base_addr;
              r_busy        <= 1'b1;
            end
          end
        end
        READ: begin
          if (r_word == LAST_WORD) begin
            r_mem_rd_en <= 1'b0;
            r_word      <= '0;
            r_state     <= DRAIN;
          end else begin
            r_word        <= r_word + CNT_W'(1);
            r_mem_rd_addr <= r_mem_rd_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: r_state <= WAIT_REFRESH;
        WAIT_REFRESH: begin
          if (row_ready) begin
            r_row_cnt <= r_row_cnt + 8'd1;
            if (w_more_rows) begin
              r_row_base    <= w_next_base;
              r_mem_rd_addr <= w_next_base;
              r_mem_rd_en   <= 1'b1;
              r_state       <= READ;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          // A zero-row request arrives without done armed and lingers one cycle to pulse it.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_FEED_STALL_CNT_EN
  logic [15:0] r_stall;

  // Saturating count of cycles a finished row waits on row_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall <= '0;
    end else if ((r_state == WAIT_REFRESH) && !row_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

  assign mem_rd_en              = r_mem_rd_en;
  assign mem_rd_addr            = r_mem_rd_addr;
  assign out_serial             = mem_rd_data;
  assign begin_serial_in        = r_begin;
  assign refresh_parallel_array = w_refresh;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign row_cnt                = r_row_cnt;

endmodule

// File: tb/tb_serial_feed_ctrl.sv
// Self-checking bench for serial_feed_ctrl: per-cycle comparison against a timeline model.
module tb_serial_feed_ctrl;

  localparam int unsigned AW   = 10;
  localparam int unsigned NUMW = 3;
  localparam int unsigned IW   = 16;
  localparam int          MAXC = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] row_stride;
  logic [7:0]    num_rows;
  logic          row_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [IW-1:0] mem_rd_data;
  logic [IW-1:0] out_serial;
  logic          begin_serial_in;
  logic          refresh_parallel_array;
  logic          busy;
  logic          done;
  logic [7:0]    row_cnt;
  logic [15:0]   stall_cycles;
  logic [IW-1:0] mem_q = '0;

  int vec = 0;
  int errs = 0;

  bit            rr     [MAXC];
  bit            e_rd   [MAXC];
  bit            e_beg  [MAXC];
  bit            e_ref  [MAXC];
  bit            e_busy [MAXC];
  bit            e_done [MAXC];
  bit            e_wait [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  int            e_rcnt [MAXC];
  int            e_stall[MAXC];
  int            e_len;
  int            e_done_t;

  always #5 clk = ~clk;

  serial_feed_ctrl #(.IN_WIDTH(IW), .NUM(NUMW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .num_rows(num_rows), .row_ready(row_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_serial(out_serial), .begin_serial_in(begin_serial_in),
    .refresh_parallel_array(refresh_parallel_array), .busy(busy), .done(done),
    .row_cnt(row_cnt), .stall_cycles(stall_cycles)
  );

  function automatic logic [IW-1:0] mem_f(input logic [AW-1:0] a);
    return {a, 6'h2b} ^ 16'h3c00;
  endfunction

  // One-cycle read latency buffer
  always @(posedge clk) if (mem_rd_en) mem_q <= mem_f(mem_rd_addr);
  assign mem_rd_data = mem_q;

  task automatic gen_rr(input int mode);
    for (int i = 0; i < MAXC; i++) begin
      if (mode == 2 && i < 200) rr[i] = ($urandom_range(0, 3) != 0);
      else if (mode == 1)       rr[i] = !(i >= 5 && i <= 8);
      else                      rr[i] = 1'b1;
    end
  endtask

  // Timeline model: row r reads at t..t+NUM-1, waits from t+NUM+1 for row_ready, refreshes, next row at refresh+1.
  task automatic build_model(input logic [AW-1:0] b, input logic [AW-1:0] s, input int nr);
    int t;
    int w;
    int nref;
    int nst;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_beg[i] = 0; e_ref[i] = 0; e_busy[i] = 0;
      e_done[i] = 0; e_wait[i] = 0; e_addr[i] = '0; e_rcnt[i] = 0; e_stall[i] = 0;
    end
    t = 1;
    e_done_t = 2;
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < int'(NUMW); k++) begin
        e_rd[t+k]   = 1;
        e_addr[t+k] = AW'(int'(b) + r * int'(s) + k);
      end
      e_beg[t+1] = 1;
      w = t + int'(NUMW) + 1;
      while (!rr[w] && w < MAXC - 16) begin
        e_wait[w] = 1;
        w++;
      end
      for (int j = t; j <= w; j++) e_busy[j] = 1;
      e_ref[w] = 1;
      t = w + 1;
      e_done_t = w + 1;
    end
    e_done[e_done_t] = 1;
    e_len = e_done_t + 2;
    nref = 0;
    nst = 0;
    for (int off = 1; off <= e_len; off++) begin
      if (e_ref[off-1] && off > 1) nref++;
      if (e_wait[off-1] && off > 1) nst++;
      e_rcnt[off] = nref;
`ifdef SERIAL_FEED_STALL_CNT_EN
      e_stall[off] = nst;
`else
      e_stall[off] = 0;
`endif
    end
  endtask

  // Runs one transfer with the model built beforehand; stray_off<0 means pulse start in the done cycle.
  task automatic test_transfer(input string nm, input logic [AW-1:0] b, input logic [AW-1:0] s,
                               input int nr, input int stray_arg);
    int stray_off;
    build_model(b, s, nr);
    stray_off = (stray_arg < 0) ? e_done_t : stray_arg;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; row_stride = s; num_rows = 8'(nr); row_ready = rr[0];
    @(negedge clk);
    vec++;
    if (mem_rd_en !== 1'b0 || busy !== 1'b0 || refresh_parallel_array !== 1'b0) begin
      errs++;
      $display("FAIL %s idle@0: rd_en=%0b busy=%0b ref=%0b, required all 0", nm, mem_rd_en, busy, refresh_parallel_array);
    end
    for (int off = 1; off <= e_len; off++) begin
      @(posedge clk); #1;
      start = (off == stray_off);
      if (off == stray_off) begin base_addr = ~b; num_rows = 8'd7; end
      row_ready = rr[off];
      @(negedge clk);
      vec++;
      if (mem_rd_en !== e_rd[off]) begin
        errs++; $display("FAIL %s rd_en@%0d: got %0b need %0b", nm, off, mem_rd_en, e_rd[off]);
      end
      if (e_rd[off]) begin
        vec++;
        if (mem_rd_addr !== e_addr[off]) begin
          errs++; $display("FAIL %s addr@%0d: got %h need %h", nm, off, mem_rd_addr, e_addr[off]);
        end
      end
      if (e_rd[off-1]) begin
        vec++;
        if (out_serial !== mem_f(e_addr[off-1])) begin
          errs++; $display("FAIL %s serial@%0d: got %h need %h", nm, off, out_serial, mem_f(e_addr[off-1]));
        end
      end
      vec++;
      if (begin_serial_in !== e_beg[off]) begin
        errs++; $display("FAIL %s begin@%0d: got %0b need %0b", nm, off, begin_serial_in, e_beg[off]);
      end
      vec++;
      if (refresh_parallel_array !== e_ref[off]) begin
        errs++; $display("FAIL %s refresh@%0d: got %0b need %0b", nm, off, refresh_parallel_array, e_ref[off]);
      end
      vec++;
      if (busy !== e_busy[off]) begin
        errs++; $display("FAIL %s busy@%0d: got %0b need %0b", nm, off, busy, e_busy[off]);
      end
      vec++;
      if (done !== e_done[off]) begin
        errs++; $display("FAIL %s done@%0d: got %0b need %0b", nm, off, done, e_done[off]);
      end
      vec++;
      if (row_cnt !== 8'(e_rcnt[off])) begin
        errs++; $display("FAIL %s row_cnt@%0d: got %0d need %0d", nm, off, row_cnt, e_rcnt[off]);
      end
      vec++;
      if (stall_cycles !== 16'(e_stall[off])) begin
        errs++; $display("FAIL %s stall@%0d: got %0d need %0d", nm, off, stall_cycles, e_stall[off]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; row_ready = 1'b1;
    base_addr = '0; row_stride = '0; num_rows = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({mem_rd_en, begin_serial_in, refresh_parallel_array, busy, done} !== 5'b0 ||
        mem_rd_addr !== '0 || row_cnt !== 8'd0 || stall_cycles !== 16'd0) begin
      errs++;
      $display("FAIL reset_state: en=%0b beg=%0b ref=%0b busy=%0b done=%0b addr=%h rc=%0d st=%0d, required all 0",
               mem_rd_en, begin_serial_in, refresh_parallel_array, busy, done, mem_rd_addr, row_cnt, stall_cycles);
    end
    @(posedge clk); #1;
    start = 1'b1; num_rows = 8'd2; base_addr = 10'h010; row_stride = 10'd4;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
        errs++; $display("FAIL reset_over_start@%0d: busy=%0b rd_en=%0b, required 0 0", i, busy, mem_rd_en);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h010; row_stride = 10'd4; num_rows = 8'd2; row_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    vec++;
    if ({mem_rd_en, begin_serial_in, refresh_parallel_array, busy, done} !== 5'b0 ||
        mem_rd_addr !== '0 || row_cnt !== 8'd0 || stall_cycles !== 16'd0) begin
      errs++;
      $display("FAIL mid_reset: en=%0b beg=%0b ref=%0b busy=%0b done=%0b addr=%h rc=%0d, required all 0",
               mem_rd_en, begin_serial_in, refresh_parallel_array, busy, done, mem_rd_addr, row_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vec++;
      if (refresh_parallel_array !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) begin
        errs++; $display("FAIL mid_reset_quiet@%0d: ref=%0b done=%0b rd_en=%0b, required 0 0 0",
                         i, refresh_parallel_array, done, mem_rd_en);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; row_ready = 1'b1;
    base_addr = '0; row_stride = '0; num_rows = '0;
    test_reset();
    gen_rr(0); test_transfer("basic", 10'h010, 10'd4, 2, 0);
    gen_rr(1); test_transfer("backpressure", 10'h010, 10'd4, 2, 0);
    gen_rr(0); test_transfer("wrap", 10'h3FE, 10'd4, 1, 0);
    gen_rr(0); test_transfer("zero_rows", 10'h020, 10'd4, 0, 0);
    gen_rr(0); test_transfer("busy_start", 10'h010, 10'd4, 2, 3);
    gen_rr(0); test_transfer("finish_start", 10'h010, 10'd4, 2, -1);
    test_mid_reset();
    gen_rr(0); test_transfer("after_reset", 10'h010, 10'd4, 2, 0);
    for (int n = 0; n < 8; n++) begin
      gen_rr(2);
      test_transfer("random", AW'($urandom), AW'($urandom), int'($urandom_range(0, 5)), 0);
    end
    gen_rr(2); test_transfer("back_to_back", 10'h3F0, 10'h3FC, 4, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
